// File: rtl/gerador_de_sequencia.sv
// Serial pattern transmitter: shifts a programmable 1..PAT_W bit pattern out MSB-first,
// repeated a programmable number of times with an optional idle gap between repetitions.
module gerador_de_sequencia #(
  parameter int   PAT_W    = 8,
  parameter int   REP_W    = 4,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PAT_W-1:0]       pattern,
  input  logic [$clog2(PAT_W):0] pat_len,
  input  logic [REP_W-1:0]       reps,
  input  logic [GAP_W-1:0]       gap,
  output logic                   out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LW = $clog2(PAT_W) + 1;
  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   patReg_q, patReg_d;
  logic [LW-1:0]      lenReg_q, lenReg_d;
  logic [GAP_W-1:0]   gapReg_q, gapReg_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [REP_W-1:0]   repCnt_q, repCnt_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
  logic               out_q, out_d;
  logic               outValid_q, outValid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [IW-1:0]      startIdx, lastIdx, prevIdx;
  logic               legal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      patReg_q   <= '0;
      lenReg_q   <= '0;
      gapReg_q   <= '0;
      idx_q      <= '0;
      repCnt_q   <= '0;
      gapCnt_q   <= '0;
      out_q      <= IDLE_BIT;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      patReg_q   <= patReg_d;
      lenReg_q   <= lenReg_d;
      gapReg_q   <= gapReg_d;
      idx_q      <= idx_d;
      repCnt_q   <= repCnt_d;
      gapCnt_q   <= gapCnt_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Outputs are computed for the state being entered so they can be registered
  // and still show the first pattern bit in the cycle right after start.
  always_comb begin
    state_d    = state_q;
    patReg_d   = patReg_q;
    lenReg_d   = lenReg_q;
    gapReg_d   = gapReg_q;
    idx_d      = idx_q;
    repCnt_d   = repCnt_q;
    gapCnt_d   = gapCnt_q;
    out_d      = IDLE_BIT;
    outValid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    startIdx = IW'(pat_len - LW'(1));
    lastIdx  = IW'(lenReg_q - LW'(1));
    prevIdx  = idx_q - IW'(1);
    legal    = (pat_len != '0) && (pat_len <= LW'(PAT_W)) && (reps != '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            state_d    = SEND;
            patReg_d   = pattern;
            lenReg_d   = pat_len;
            repCnt_d   = reps;
            gapReg_d   = gap;
            idx_d      = startIdx;
            out_d      = pattern[startIdx];
            outValid_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q != '0) begin
          idx_d      = prevIdx;
          out_d      = patReg_q[prevIdx];
          outValid_d = 1'b1;
          busy_d     = 1'b1;
        end else if (repCnt_q == REP_W'(1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          repCnt_d = repCnt_q - REP_W'(1);
          if (gapReg_q == '0) begin
            idx_d      = lastIdx;
            out_d      = patReg_q[lastIdx];
            outValid_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            state_d  = GAP;
            gapCnt_d = gapReg_q;
            busy_d   = 1'b1;
          end
        end
      end
      // gapCnt_q counts the gap cycles still to show, including the current one
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gapCnt_q == GAP_W'(1)) begin
          state_d    = SEND;
          idx_d      = lastIdx;
          out_d      = patReg_q[lastIdx];
          outValid_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q - GAP_W'(1);
          busy_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out       = out_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/gerador_de_sequencia.md
# gerador_de_sequencia

- Serial pattern transmitter that drives the single-bit `in` stream consumed by the sequence detector.
- Loads a programmable pattern of 1..PAT_W bits and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Produces stimulus for the detector in benches and on-chip self-test.

## Interface
Parameters:
- PAT_W, 8, maximum pattern length in bits
- REP_W, 4, width of repetition count
- GAP_W, 4, width of inter-repetition gap count
- IDLE_BIT, 1'b1, level driven on `out` when not sending a pattern bit

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  request to begin a transfer; sampled only in IDLE
- abort  in  1  synchronous cancel of a running transfer
- pattern  in  PAT_W  pattern bits; field pattern[pat_len-1:0] is sent
- pat_len  in  $clog2(PAT_W)+1  number of bits per repetition, legal 1..PAT_W
- reps  in  REP_W  number of repetitions, legal 1..2^REP_W-1
- gap  in  GAP_W  IDLE_BIT cycles inserted between repetitions, 0 allowed
- out  out  1  serial bit stream
- out_valid  out  1  high while `out` carries a pattern bit
- busy  out  1  high from first bit to last bit, including gaps
- done  out  1  one-cycle pulse after normal completion
- err  out  1  one-cycle pulse when start carries an illegal configuration

## Operation
- FSM states: IDLE, SEND, GAP, FINISH. All outputs are registered.
- IDLE:
  - out=IDLE_BIT; out_valid=0; busy=0.
  - On start=1, capture pattern, pat_len, reps and gap into internal registers.
  - Later changes to these inputs have no effect until the next accepted start.
- Legal configuration: start with pat_len in 1..PAT_W and reps≥1 → SEND.
- Illegal configuration: start with pat_len=0, pat_len>PAT_W or reps=0 → err=1 for one cycle; state stays IDLE; nothing is sent.
- SEND:
  - Bit index starts at pat_len-1 and decrements each cycle.
  - out=pattern_reg[idx]; out_valid=1; busy=1.
  - When idx=0 and this is the last repetition → FINISH.
  - When idx=0 and repetitions remain: gap=0 → reload idx and stay in SEND (back-to-back, no bubble); gap>0 → GAP.
- GAP:
  - out=IDLE_BIT; out_valid=0; busy=1.
  - Lasts exactly `gap` cycles, then → SEND with idx reloaded to pat_len-1.
- FINISH:
  - One cycle only, then → IDLE.
  - done=1; busy=0; out=IDLE_BIT; out_valid=0.
- start while in SEND, GAP or FINISH is ignored; no queuing, no err.
- abort=1 in SEND or GAP:
  - Next cycle state=IDLE and all outputs at idle values.
  - No done, no err.
  - abort in IDLE or FINISH has no effect; FINISH still pulses done.
- abort and start both high in IDLE: start wins.
- rst=0:
  - Next edge: state=IDLE, counters cleared, out=IDLE_BIT, out_valid=0, busy=0, done=0, err=0.
  - Takes effect from any state, including mid-pattern; overrides start and abort.

## Timing
- Outputs after reset: out=IDLE_BIT, out_valid=0, busy=0, done=0, err=0.
- Start accepted at edge N → first pattern bit on `out` during cycle N+1.
- Each bit lasts exactly one clock.
- Total busy cycles = reps·pat_len + (reps−1)·gap.
- Last bit in cycle L → done=1 in cycle L+1; IDLE in L+2; next start is accepted at edge L+2.
- err is asserted in the cycle after the illegal start.
- Counter widths must hold pat_len=PAT_W, reps=2^REP_W−1 and gap=2^GAP_W−1 without wrap-around.

## Test plan
- Single pattern: pattern=8'h06, pat_len=4, reps=1, gap=0, start at cycle 0 → out=0,1,1,0 in cycles 1–4; out_valid=1 in cycles 1–4; done=1 in cycle 5. Loopback into the detector gives s=1 once.
- Back-to-back repeats: pattern=0110, reps=3, gap=0 → 12 contiguous valid bits 011001100110; busy high for 12 cycles; detector reports 3 hits.
- Gap insertion: pattern=2'b01, pat_len=2, reps=2, gap=3 → out=0,1,1,1,1,0,1 in cycles 1–7; out_valid=1,1,0,0,0,1,1; done in cycle 8.
- Illegal and ignored starts: pat_len=0 or reps=0 → err pulse in cycle 1, busy stays 0. start while busy → no effect, bit sequence unchanged.
- Full width: pattern=8'hA5, pat_len=8, reps=15, gap=15 → 120 valid bits in the correct MSB-first order; busy lasts 330 cycles.
- Abort and reset mid-transfer: abort at the 2nd bit → IDLE next cycle, no done. rst=0 mid-gap → all outputs at reset values next cycle; a fresh start afterwards behaves as in the single-pattern test.
